memory_map: RTL and testbench
=============================

MEMORY_MAP -- requirements
Module: memory_map

Interface
REQ-001 Parameter RAM_WORDS, default 16384, number of 16-bit general data RAM words at 0x0000-0x3FFF.
REQ-002 Parameter SCR_FIFO_DEPTH, default 4, depth of the screen-write FIFO; power of two, 2..8.
REQ-003 CLK  in  1  system clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 addressM  in  15  CPU data address.
REQ-006 outM  in  16  CPU write data.
REQ-007 writeM  in  1  CPU write enable.
REQ-008 inM  out  16  read data returned to CPU.
REQ-009 scr_addr  out  13  screen word offset of FIFO head entry.
REQ-010 scr_data  out  16  screen pixel word of FIFO head entry.
REQ-011 scr_valid  out  1  FIFO non-empty; head entry presented.
REQ-012 scr_ready  in  1  screen sink accepts head entry this cycle.
REQ-013 scr_overflow  out  1  sticky flag; a screen write was dropped.
REQ-014 kbd_code  in  16  current key code from keyboard front end; 0 = no key.
REQ-015 kbd_strobe  in  1  one-cycle pulse; kbd_code is valid to capture.

Function
REQ-016 Decode: 0x0000-0x3FFF RAM; 0x4000-0x5FFF screen; 0x6000 KBD; 0x6001 STATUS; all other addresses unmapped.
REQ-017 inM shall be combinational from addressM and current state, valid in the same cycle (zero-latency read).
REQ-018 Unmapped reads return 0x0000; unmapped writes have no effect.
REQ-019 RAM write occurs at posedge when writeM=1 and address in RAM region; new value readable the following cycle.
REQ-020 Screen region holds an 8K-word shadow RAM; reads return the last value written to that offset.
REQ-021 Screen write updates the shadow RAM and pushes {addressM[12:0], outM} into the FIFO in the same posedge.
REQ-022 scr_valid=1 exactly when FIFO count>0; scr_addr/scr_data show the oldest entry and hold stable while scr_valid=1 and scr_ready=0.
REQ-023 Pop occurs at posedge when scr_valid=1 and scr_ready=1; scr_ready while empty has no effect.
REQ-024 Push while full with no pop in the same cycle: entry dropped, FIFO unchanged, shadow RAM still updated, scr_overflow set to 1.
REQ-025 Simultaneous push and pop while full: both performed, count unchanged, no overflow.
REQ-026 FIFO pointers wrap modulo SCR_FIFO_DEPTH; count ranges 0..SCR_FIFO_DEPTH.
REQ-027 kbd_strobe=1 at posedge: KBD <= kbd_code, kbd_new <= 1; KBD holds until the next strobe.
REQ-028 Read 0x6000 returns KBD; reading does not alter kbd_new.
REQ-029 STATUS read: bit0 kbd_new, bit1 scr_overflow, bit2 FIFO full, bits[6:3] FIFO count, bits[15:7] zero.
REQ-030 STATUS write: outM bit0=1 clears kbd_new, bit1=1 clears scr_overflow; other bits ignored; writes to 0x6000 ignored.
REQ-031 kbd_strobe coincident with a kbd_new clear: set wins, kbd_new=1, KBD updated.
REQ-032 Overflow event coincident with an overflow clear: set wins, scr_overflow=1.

Reset
REQ-033 reset=1 immediately (asynchronously) forces: FIFO empty, scr_valid=0, scr_overflow=0, KBD=0x0000, kbd_new=0.
REQ-034 RAM and screen shadow contents are not cleared by reset.
REQ-035 reset asserted mid-stream discards all queued FIFO entries; no pop is reported after release until a new push.
REQ-036 While reset=1, writes and strobes are ignored; inM still decodes combinationally.

Verification
REQ-037 Write 0x1234 to 0x0010, next cycle addressM=0x0010 -> inM=0x1234 same cycle; addressM=0x7000 -> inM=0x0000.
REQ-038 scr_ready=0, five writes to 0x4000..0x4004 (DEPTH=4) -> count=4, STATUS=0x0026, scr_overflow=1, read 0x4004 returns written data.
REQ-039 Then scr_ready=1 -> four pops in order, offsets 0x0000..0x0003, scr_valid=0 after fourth; write 0x0002 to 0x6001 -> scr_overflow=0.
REQ-040 FIFO full, write and scr_ready=1 in same cycle -> count stays 4, scr_overflow stays 0, new entry appears after three further pops.
REQ-041 kbd_strobe with kbd_code=0x0041 -> read 0x6000=0x0041, STATUS bit0=1; write 0x0001 to 0x6001 with strobe kbd_code=0x0042 same cycle -> kbd_new=1, KBD=0x0042.
REQ-042 Three FIFO entries queued, reset pulsed between clock edges -> scr_valid=0 before next posedge, STATUS=0x0000, RAM word 0x0010 still 0x1234.

Source files
------------

// File: rtl/memory_map.sv
// Memory map: data RAM, screen shadow RAM with an outbound screen-write FIFO,
// a keyboard latch and a status register. Reads are zero-latency and combinational.
module memory_map #(
  parameter int RAM_WORDS      = 16384,
  parameter int SCR_FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow,
  input  logic [15:0] kbd_code,
  input  logic        kbd_strobe
);
  localparam int              RAW         = $clog2(RAM_WORDS);
  localparam int              PW          = $clog2(SCR_FIFO_DEPTH);
  localparam int              CW          = PW + 1;
  localparam logic [14:0]     RAM_LIMIT   = 15'(RAM_WORDS);
  localparam logic [14:0]     KBD_ADDR    = 15'h6000;
  localparam logic [14:0]     STATUS_ADDR = 15'h6001;
  localparam logic [CW-1:0]   FIFO_FULL   = CW'(SCR_FIFO_DEPTH);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE     = PW'(1);

  logic [15:0] ram_mem  [RAM_WORDS];
  logic [15:0] scr_mem  [8192];
  logic [28:0] fifo_mem [SCR_FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   kbd_q, kbd_d;
  logic          kbd_new_q, kbd_new_d;
  logic          ovf_q, ovf_d;

  logic ram_hit_s, scr_hit_s, kbd_hit_s, stat_hit_s;
  logic wr_en_s, stat_wr_s, scr_push_s, scr_pop_s, push_ok_s, drop_s, fifo_full_s;
  logic [15:0] status_s;

  assign ram_hit_s   = (addressM < RAM_LIMIT);
  assign scr_hit_s   = (addressM[14:13] == 2'b10);
  assign kbd_hit_s   = (addressM == KBD_ADDR);
  assign stat_hit_s  = (addressM == STATUS_ADDR);

  // Writes are suppressed while reset is held.
  assign wr_en_s     = writeM & ~reset;
  assign stat_wr_s   = wr_en_s & stat_hit_s;
  assign scr_push_s  = wr_en_s & scr_hit_s;
  assign fifo_full_s = (count_q == FIFO_FULL);
  assign scr_valid   = (count_q != {CW{1'b0}});
  assign scr_pop_s   = scr_valid & scr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok_s   = scr_push_s & (~fifo_full_s | scr_pop_s);
  assign drop_s      = scr_push_s & fifo_full_s & ~scr_pop_s;

  assign status_s     = {9'h000, 4'(count_q), fifo_full_s, ovf_q, kbd_new_q};
  assign scr_addr     = fifo_mem[rd_ptr_q][28:16];
  assign scr_data     = fifo_mem[rd_ptr_q][15:0];
  assign scr_overflow = ovf_q;

  always_comb begin
    inM = 16'h0000;
    if (ram_hit_s) begin
      inM = ram_mem[addressM[RAW-1:0]];
    end else if (scr_hit_s) begin
      inM = scr_mem[addressM[12:0]];
    end else if (kbd_hit_s) begin
      inM = kbd_q;
    end else if (stat_hit_s) begin
      inM = status_s;
    end else begin
      inM = 16'h0000;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    kbd_d     = kbd_q;
    kbd_new_d = kbd_new_q;
    ovf_d     = ovf_q;

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (scr_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, scr_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Set beats clear for both sticky status bits.
    if (kbd_strobe) begin
      kbd_d     = kbd_code;
      kbd_new_d = 1'b1;
    end else if (stat_wr_s && outM[0]) begin
      kbd_new_d = 1'b0;
    end else begin
      kbd_new_d = kbd_new_q;
    end

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (stat_wr_s && outM[1]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      kbd_q     <= 16'h0000;
      kbd_new_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      kbd_q     <= kbd_d;
      kbd_new_q <= kbd_new_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage arrays keep their contents across reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s && ram_hit_s) begin
      ram_mem[addressM[RAW-1:0]] <= outM;
    end
    if (scr_push_s) begin
      scr_mem[addressM[12:0]] <= outM;
    end
    if (push_ok_s) begin
      fifo_mem[wr_ptr_q] <= {addressM[12:0], outM};
    end
  end
endmodule

// File: tb/tb_memory_map.sv
// Directed bench for memory_map: direct read checks plus a scoreboard queue
// of expected screen-FIFO entries drained by an independent monitor.
module tb_memory_map;
  logic        CLK = 1'b0;
  logic        reset;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready;
  logic        scr_overflow;
  logic [15:0] kbd_code;
  logic        kbd_strobe;

  int n_checks = 0;
  int n_fail   = 0;
  logic [28:0] exp_q [$];

  memory_map #(.RAM_WORDS(16384), .SCR_FIFO_DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .scr_addr(scr_addr), .scr_data(scr_data), .scr_valid(scr_valid),
    .scr_ready(scr_ready), .scr_overflow(scr_overflow), .kbd_code(kbd_code),
    .kbd_strobe(kbd_strobe)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string name);
    addressM = a;
    writeM   = 1'b0;
    #1;
    chk(name, {16'h0000, inM}, {16'h0000, exp});
  endtask

  task automatic wr(input logic [14:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    tick();
    writeM   = 1'b0;
  endtask

  task automatic scr_wr(input logic [14:0] a, input logic [15:0] d, input bit accepted);
    if (accepted) exp_q.push_back({a[12:0], d});
    wr(a, d);
  endtask

  // Monitor: every accepted head entry must match the oldest expected entry.
  always @(negedge CLK) begin
    logic [28:0] e;
    if (!reset && scr_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scr_unexpected: got entry %h/%h, expected none", scr_addr, scr_data);
      end else if (scr_ready) begin
        e = exp_q.pop_front();
        chk("scr_addr", {19'h0, scr_addr}, {19'h0, e[28:16]});
        chk("scr_data", {16'h0, scr_data}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    reset = 1'b1; addressM = 15'h0000; outM = 16'h0000; writeM = 1'b0;
    scr_ready = 1'b0; kbd_code = 16'h0000; kbd_strobe = 1'b0;

    // Writes and strobes during reset are ignored.
    addressM = 15'h4003; outM = 16'hDEAD; writeM = 1'b1;
    kbd_code = 16'h0055; kbd_strobe = 1'b1;
    tick(); tick();
    writeM = 1'b0; kbd_strobe = 1'b0;
    chk("rst_valid", {31'h0, scr_valid}, 32'h0);
    rd(15'h6001, 16'h0000, "rst_status");
    reset = 1'b0;
    tick();
    rd(15'h6000, 16'h0000, "rst_kbd");
    rd(15'h6001, 16'h0000, "post_rst_status");

    // RAM write/read and unmapped reads.
    wr(15'h0010, 16'h1234);
    rd(15'h0010, 16'h1234, "ram_rd");
    rd(15'h7000, 16'h0000, "unmapped_7000");
    rd(15'h6002, 16'h0000, "unmapped_6002");
    wr(15'h3FFF, 16'h5A5A);
    rd(15'h3FFF, 16'h5A5A, "ram_top");

    // Fill the FIFO past capacity with the sink stalled.
    scr_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      scr_wr(15'h4000 + 15'(i), 16'hA000 + 16'(i), i < 4);
    rd(15'h6001, 16'h0026, "status_full_ovf");
    rd(15'h4004, 16'hA004, "shadow_dropped");
    rd(15'h4000, 16'hA000, "shadow_first");
    chk("ovf_flag", {31'h0, scr_overflow}, 32'h1);
    tick();
    chk("hold_addr", {19'h0, scr_addr}, 32'h0);
    chk("hold_data", {16'h0, scr_data}, 32'hA000);

    // Drain in order, then clear the overflow flag.
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drained_valid", {31'h0, scr_valid}, 32'h0);
    rd(15'h6001, 16'h0002, "status_ovf_only");
    wr(15'h6001, 16'h0002);
    chk("ovf_cleared", {31'h0, scr_overflow}, 32'h0);
    rd(15'h6001, 16'h0000, "status_clear");

    // Push and pop together while full.
    scr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      scr_wr(15'h4010 + 15'(i), 16'hB000 + 16'(i), 1'b1);
    scr_ready = 1'b1;
    scr_wr(15'h4020, 16'hBEEF, 1'b1);
    scr_ready = 1'b0;
    rd(15'h6001, 16'h0024, "status_full_noovf");
    chk("no_ovf", {31'h0, scr_overflow}, 32'h0);
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("drained2_valid", {31'h0, scr_valid}, 32'h0);

    // Keyboard latch and set-wins-over-clear.
    kbd_code = 16'h0041; kbd_strobe = 1'b1;
    tick();
    kbd_strobe = 1'b0;
    rd(15'h6000, 16'h0041, "kbd_41");
    rd(15'h6001, 16'h0001, "status_kbd_new");
    rd(15'h6001, 16'h0001, "kbd_new_sticky");
    kbd_code = 16'h0042; kbd_strobe = 1'b1;
    wr(15'h6001, 16'h0001);
    kbd_strobe = 1'b0;
    rd(15'h6000, 16'h0042, "kbd_42");
    rd(15'h6001, 16'h0001, "kbd_set_wins");
    wr(15'h6001, 16'h0001);
    rd(15'h6001, 16'h0000, "kbd_new_clear");
    wr(15'h6000, 16'hFFFF);
    rd(15'h6000, 16'h0042, "kbd_write_ignored");

    // Reset pulse between edges with three entries queued.
    scr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      scr_wr(15'h4100 + 15'(i), 16'hC000 + 16'(i), 1'b1);
    rd(15'h6001, 16'h0018, "status_three");
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_valid", {31'h0, scr_valid}, 32'h0);
    rd(15'h6001, 16'h0000, "midrst_status");
    reset = 1'b0;
    rd(15'h0010, 16'h1234, "ram_survives");
    scr_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_valid", {31'h0, scr_valid}, 32'h0);
    rd(15'h4004, 16'hA004, "shadow_survives");
    scr_wr(15'h4005, 16'h1111, 1'b1);
    tick(); tick();
    chk("queue_empty", exp_q.size(), 32'h0);
    chk("final_valid", {31'h0, scr_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
